// File: rtl/scroll_controller_pkg.sv
// Shared types and helpers for the scroll-offset generator.
package scroll_pkg;

  localparam int unsigned SPEED_W = 4;

  // Legacy state encodings, kept so the enum values stay bit-identical.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } scroll_state_t;

  // Saturate v at hi.
  function automatic int unsigned clamp(input int unsigned v, input int unsigned hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/scroll_controller_lane_slewer.sv
// Next horizontal offset: jump onto the target when within one step,
// otherwise move exactly one step toward it.
module lane_slewer #(
  parameter int unsigned HWIDTH = 10,
  parameter int unsigned STEP   = 4
) (
  input  logic [HWIDTH-1:0] cur,
  input  logic [HWIDTH-1:0] target,
  output logic [HWIDTH-1:0] next
);

  localparam logic [HWIDTH-1:0] STEP_W = HWIDTH'(STEP);

  logic [HWIDTH-1:0] diff;

  // Compare first so each subtraction is ordered large-minus-small.
  always_comb begin
    diff = '0;
    next = cur;
    if (target >= cur) begin
      diff = target - cur;
      next = (diff <= STEP_W) ? target : cur + STEP_W;
    end else begin
      diff = cur - target;
      next = (diff <= STEP_W) ? target : cur - STEP_W;
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Per-frame scroll-offset generator: vertical wrap scroll with speed ramp
// and horizontal slew toward the requested lane.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int unsigned HWIDTH      = 10,
  parameter int unsigned VWIDTH      = 10,
  parameter int unsigned HSIZE       = 640,
  parameter int unsigned VSIZE       = 480,
  parameter int unsigned SPEED_MAX   = 8,
  parameter int unsigned RAMP_FRAMES = 120,
  parameter int unsigned LANE_STEP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               run,
  input  logic               restart,
  input  logic [HWIDTH-1:0]  lane_target,
  output logic [HWIDTH-1:0]  hoffset,
  output logic [VWIDTH-1:0]  voffset,
  output logic [SPEED_W-1:0] speed,
  output logic               running,
  output logic               lane_settled
);

  localparam int unsigned RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RW-1:0]      RAMP_LAST = RW'(RAMP_FRAMES - 1);
  localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(SPEED_MAX);
  localparam logic [VWIDTH:0]    VSIZE_W   = (VWIDTH + 1)'(VSIZE);

  scroll_state_t      state_q;
  scroll_state_t      state_d;
  logic [RW-1:0]      ramp_cnt;
  logic [HWIDTH-1:0]  target_c;
  logic [HWIDTH-1:0]  h_next;
  logic [VWIDTH:0]    vsum;
  logic [VWIDTH-1:0]  v_next;
  logic               update;

  assign target_c     = HWIDTH'(clamp(32'(lane_target), HSIZE - 1));
  assign update       = (state_q == RUN) && run && !restart && frame_tick;
  assign running      = (state_q == RUN);
  assign lane_settled = (hoffset == target_c);

  lane_slewer #(
    .HWIDTH (HWIDTH),
    .STEP   (LANE_STEP)
  ) u_slewer (
    .cur    (hoffset),
    .target (target_c),
    .next   (h_next)
  );

  // Vertical advance with single-subtraction wrap (speed < VSIZE).
  always_comb begin
    vsum   = {1'b0, voffset} + (VWIDTH + 1)'(speed);
    v_next = VWIDTH'((vsum >= VSIZE_W) ? (vsum - VSIZE_W) : vsum);
  end

  // Run/pause control; restart overrides everything.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run)  state_d = RUN;
        RUN:     if (!run) state_d = PAUSE;
        PAUSE:   if (run)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Offsets, speed and ramp counter: cleared on restart, advanced once per running frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hoffset  <= '0;
      voffset  <= '0;
      speed    <= SPEED_W'(1);
      ramp_cnt <= '0;
    end else if (restart) begin
      hoffset  <= '0;
      voffset  <= '0;
      speed    <= SPEED_W'(1);
      ramp_cnt <= '0;
    end else if (update) begin
      hoffset <= h_next;
      voffset <= v_next;
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt <= '0;
        if (speed != SPEED_TOP) speed <= speed + 1'b1;
      end else begin
        ramp_cnt <= ramp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scroll_controller.sv
// Bench for scroll_controller: two instances (default ramp and fast ramp)
// checked every cycle against a frame-count based model, plus directed
// literal expectations and a standalone lane_slewer check.
module tb_scroll_controller;

  localparam int HS = 640;
  localparam int VS = 480;
  localparam int SMAX = 8;
  localparam int LSTEP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] lane_target = '0;

  logic [9:0] ha, va, hb, vb;
  logic [3:0] sa, sb;
  logic       runa, runb, seta, setb;

  logic [9:0] ls_cur, ls_tgt, ls_nxt;

  always #5 clk = ~clk;

  scroll_controller #(
    .HWIDTH(10), .VWIDTH(10), .HSIZE(640), .VSIZE(480),
    .SPEED_MAX(8), .RAMP_FRAMES(120), .LANE_STEP(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
    .restart(restart), .lane_target(lane_target),
    .hoffset(ha), .voffset(va), .speed(sa), .running(runa), .lane_settled(seta)
  );

  scroll_controller #(
    .RAMP_FRAMES(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
    .restart(restart), .lane_target(lane_target),
    .hoffset(hb), .voffset(vb), .speed(sb), .running(runb), .lane_settled(setb)
  );

  lane_slewer #(.HWIDTH(10), .STEP(4)) u_ls (
    .cur(ls_cur), .target(ls_tgt), .next(ls_nxt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 paused. Speed follows from frames run since idle.
  int m_mode[2];
  int m_v[2];
  int m_h[2];
  int m_f[2];
  int ramp[2] = '{120, 2};

  function automatic int clampt(input int t);
    return (t > HS - 1) ? HS - 1 : t;
  endfunction

  function automatic int m_speed(input int i);
    int s;
    s = 1 + m_f[i] / ramp[i];
    return (s > SMAX) ? SMAX : s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || restart) begin
        m_mode[i] = 0; m_v[i] = 0; m_h[i] = 0; m_f[i] = 0;
      end else begin
        if (m_mode[i] == 1 && run && frame_tick) begin
          int t;
          int d;
          m_v[i] = (m_v[i] + m_speed(i)) % VS;
          m_f[i] = m_f[i] + 1;
          t = clampt(int'(lane_target));
          d = t - m_h[i];
          if (d <= LSTEP && d >= -LSTEP) m_h[i] = t;
          else m_h[i] = m_h[i] + ((d > 0) ? LSTEP : -LSTEP);
        end
        if (m_mode[i] == 0 && run) m_mode[i] = 1;
        else if (m_mode[i] == 1 && !run) m_mode[i] = 2;
        else if (m_mode[i] == 2 && run) m_mode[i] = 1;
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    chk("a_hoffset", int'(ha), m_h[0]);
    chk("a_voffset", int'(va), m_v[0]);
    chk("a_speed", int'(sa), m_speed(0));
    chk("a_running", int'(runa), int'(m_mode[0] == 1));
    chk("a_settled", int'(seta), int'(m_h[0] == clampt(int'(lane_target))));
    chk("b_hoffset", int'(hb), m_h[1]);
    chk("b_voffset", int'(vb), m_v[1]);
    chk("b_speed", int'(sb), m_speed(1));
    chk("b_running", int'(runb), int'(m_mode[1] == 1));
    chk("b_settled", int'(setb), int'(m_h[1] == clampt(int'(lane_target))));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
  endtask

  task automatic slew_check(input int c, input int t);
    int d;
    int e;
    ls_cur = 10'(c);
    ls_tgt = 10'(t);
    #1;
    d = t - c;
    if (d <= LSTEP && d >= -LSTEP) e = t;
    else e = c + ((d > 0) ? LSTEP : -LSTEP);
    chk("slewer_next", int'(ls_nxt), e);
  endtask

  initial begin
    int exp_s;
    ls_cur = '0;
    ls_tgt = '0;

    // Reset values
    repeat (2) cyc();
    chk("reset_hoffset", int'(ha), 0);
    chk("reset_voffset", int'(va), 0);
    chk("reset_speed", int'(sa), 1);
    chk("reset_running", int'(runa), 0);
    chk("reset_settled", int'(seta), 1);
    rst_n = 1'b1;
    cyc();

    // Start running; tick in IDLE is not involved, first edge only transitions
    run = 1'b1;
    cyc();
    chk("run_entered", int'(runa), 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("slow_voffset", int'(va), k);
      chk("slow_speed", int'(sa), 1);
      exp_s = 1 + k / 2;
      if (exp_s > 8) exp_s = 8;
      chk("fast_speed", int'(sb), exp_s);
      chk("fast_vbound", int'(vb < 10'd480), 1);
    end
    chk("fast_voffset_20", int'(vb), 104);

    // Lane slew and settle
    lane_target = 10'd10;
    cyc();
    chk("lane_unsettled", int'(seta), 0);
    tick(); chk("lane_h1", int'(ha), 4);  chk("lane_s1", int'(seta), 0);
    tick(); chk("lane_h2", int'(ha), 8);  chk("lane_s2", int'(seta), 0);
    tick(); chk("lane_h3", int'(ha), 10); chk("lane_s3", int'(seta), 1);
    tick(); chk("lane_h4", int'(ha), 10); chk("lane_s4", int'(seta), 1);
    lane_target = 10'd1000;
    cyc();
    chk("clamp_unsettled", int'(seta), 0);
    tick();
    chk("clamp_h1", int'(ha), 14);
    repeat (157) tick();
    chk("clamp_h639", int'(ha), 639);
    chk("clamp_settled", int'(seta), 1);
    chk("a_voffset_182", int'(va), 244);
    chk("a_speed_182", int'(sa), 2);

    // Long ramp on default instance, exact wrap to zero
    do_restart();
    chk("restart_v", int'(va), 0);
    repeat (360) tick();
    chk("ramp_v360", int'(va), 240);
    chk("ramp_s360", int'(sa), 4);
    repeat (59) tick();
    chk("ramp_v419", int'(va), 476);
    tick();
    chk("wrap_to_zero", int'(va), 0);

    // Pause: run drops on a tick cycle
    run = 1'b0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk("pause_running", int'(runa), 0);
    chk("pause_v", int'(va), 0);
    repeat (5) tick();
    chk("pause_v_held", int'(va), 0);
    chk("pause_h_held", int'(ha), 639);
    chk("pause_s_held", int'(sa), 4);
    // Resume with coincident tick: transition only
    run = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk("resume_running", int'(runa), 1);
    chk("resume_no_update", int'(va), 0);
    tick();
    chk("resume_first_update", int'(va), 4);

    // Restart coincident with tick
    frame_tick = 1'b1;
    restart = 1'b1;
    cyc();
    frame_tick = 1'b0;
    restart = 1'b0;
    chk("rst_tick_h", int'(ha), 0);
    chk("rst_tick_v", int'(va), 0);
    chk("rst_tick_s", int'(sa), 1);
    chk("rst_tick_running", int'(runa), 0);
    cyc();

    // Async reset between edges
    lane_target = 10'd100;
    repeat (3) tick();
    chk("pre_async_h", int'(ha), 12);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_h", int'(ha), 0);
    chk("async_v", int'(va), 0);
    chk("async_s", int'(sa), 1);
    chk("async_running", int'(runa), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Randomised traffic, checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) run = ~run;
      restart = ($urandom_range(0, 200) == 0);
      if ($urandom_range(0, 20) == 0) lane_target = 10'($urandom_range(0, 1023));
      cyc();
    end
    frame_tick = 1'b0;
    restart = 1'b0;
    cyc();

    // Standalone slewer corners and random pairs
    slew_check(0, 1023);
    slew_check(1023, 0);
    slew_check(0, 4);
    slew_check(0, 5);
    slew_check(5, 0);
    slew_check(4, 0);
    slew_check(1023, 1019);
    slew_check(1019, 1023);
    for (int n = 0; n < 200; n++) begin
      slew_check(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
